// File: rtl/ram_req_arbiter.sv
// Round-robin arbiter sharing one SRAM request channel, with read-order tracking via an external ID FIFO.
// Optional macro RAM_REQ_ARB_REQ0_PRIO_EN gives requester 0 absolute priority over the round-robin set.
module ram_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic                      ram_req_valid,
    input  logic                      ram_req_ready,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic                      ram_rsp_valid,
    input  logic [DATA_W-1:0]         ram_rsp_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      ord_push,
    output logic [1:0]                ord_id,
    input  logic                      ord_full,
    output logic                      ord_pop,
    input  logic [1:0]                ord_id_out,
    input  logic                      ord_empty,
    output logic                      err_rsp
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [1:0]          rr_ptr;
    logic [NUM_REQ-1:0]  elig;
    logic                load, found, gnt_vld;
    logic [1:0]          gnt_idx;
    logic                gnt_we;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_wdata;
    logic [NUM_REQ-1:0]  rsp_oh;
    logic                iss_we_p1;
    logic [ADDR_W-1:0]   iss_addr_p1;
    logic [DATA_W-1:0]   iss_wdata_p1;
    logic [NUM_REQ-1:0]  rsp_vld_p1;
    logic [DATA_W-1:0]   rsp_data_p1;
    logic                err_q;

    // Reads need a free order-FIFO slot; writes never occupy one.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (req_we[i] || !ord_full);
        end
    end

    assign load = (state_q == IDLE) || (ram_req_valid && ram_req_ready);

    always_comb begin
        int   idx;
        logic cand;
        found   = 1'b0;
        gnt_idx = 2'd0;
        idx     = 0;
        cand    = 1'b0;
`ifdef RAM_REQ_ARB_REQ0_PRIO_EN
        if (elig[0]) begin
            found = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx  = (int'(rr_ptr) + k) % NUM_REQ;
            cand = elig[idx];
`ifdef RAM_REQ_ARB_REQ0_PRIO_EN
            cand = cand && (idx != 0);
`endif
            if (!found && cand) begin
                found   = 1'b1;
                gnt_idx = 2'(idx);
            end
        end
    end

    assign gnt_vld = load && found;

    always_comb begin
        gnt_we    = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == 2'(i)) begin
                gnt_we    = req_we[i];
                gnt_addr  = req_addr[i*ADDR_W +: ADDR_W];
                gnt_wdata = req_wdata[i*DATA_W +: DATA_W];
                req_ready[i] = gnt_vld;
            end
        end
    end

    assign ord_push = gnt_vld && !gnt_we;
    assign ord_id   = gnt_idx;
    assign ord_pop  = ram_rsp_valid && !ord_empty;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_oh[i] = (ord_id_out == 2'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_vld) state_d = BUSY;
            BUSY:    if (ram_req_ready && !gnt_vld) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_req_valid = (state_q == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (gnt_vld) begin
`ifdef RAM_REQ_ARB_REQ0_PRIO_EN
            if (gnt_idx != 2'd0)
`endif
            rr_ptr <= (gnt_idx == LAST_IDX) ? 2'd0 : gnt_idx + 2'd1;
        end
    end

    // Issue stage (p1): held stable while the SRAM stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_we_p1    <= 1'b0;
            iss_addr_p1  <= '0;
            iss_wdata_p1 <= '0;
        end else if (gnt_vld) begin
            iss_we_p1    <= gnt_we;
            iss_addr_p1  <= gnt_addr;
            iss_wdata_p1 <= gnt_wdata;
        end
    end

    assign ram_we    = iss_we_p1;
    assign ram_addr  = iss_addr_p1;
    assign ram_wdata = iss_wdata_p1;

    // Response stage (p1): steer returning data to the FIFO-head owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_p1  <= '0;
            rsp_data_p1 <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_vld_p1 <= ord_pop ? rsp_oh : '0;
            if (ord_pop) begin
                rsp_data_p1 <= ram_rsp_data;
            end
            if (ram_rsp_valid && ord_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rsp_valid = rsp_vld_p1;
    assign rsp_data  = rsp_data_p1;
    assign err_rsp   = err_q;

endmodule

// File: tb/tb_ram_req_arbiter.sv
// Bench for ram_req_arbiter: directed vectors, queue scoreboard with a negedge monitor, behavioural order FIFO.
module tb_ram_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 64;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic                      ram_req_valid;
    logic                      ram_req_ready;
    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_wdata;
    logic                      ram_rsp_valid;
    logic [DATA_W-1:0]         ram_rsp_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      ord_push;
    logic [1:0]                ord_id;
    logic                      ord_full = 1'b0;
    logic                      ord_pop;
    logic [1:0]                ord_id_out = 2'd0;
    logic                      ord_empty = 1'b1;
    logic                      err_rsp;

    ram_req_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ram_req_valid(ram_req_valid), .ram_req_ready(ram_req_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rsp_valid(ram_rsp_valid), .ram_rsp_data(ram_rsp_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ord_push(ord_push), .ord_id(ord_id), .ord_full(ord_full),
        .ord_pop(ord_pop), .ord_id_out(ord_id_out), .ord_empty(ord_empty),
        .err_rsp(err_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_iss[$];
    logic [127:0] exp_rsp[$];
    logic [1:0]   exp_push[$];
    int           issued_rd[$];
    logic [1:0]   fifo_q[$];

    logic [3:0]        s_rdy, s_rsp;
    logic              s_vld, s_we, s_err, s_pop;
    logic [ADDR_W-1:0] s_addr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] pk_iss(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [127:0] r;
        r = '0;
        r[DATA_W+ADDR_W:0] = {we, a, d};
        return r;
    endfunction

    function automatic logic [127:0] pk_rsp(input logic [3:0] oh, input logic [DATA_W-1:0] d);
        logic [127:0] r;
        r = '0;
        r[DATA_W+3:0] = {oh, d};
        return r;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        return 4'(1 << i);
    endfunction

    // External 16-deep order FIFO; outputs update nonblocking so the DUT samples pre-edge values.
    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
        end else begin
            if (ord_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (ord_push) fifo_q.push_back(ord_id);
        end
        ord_full   <= (fifo_q.size() >= 16);
        ord_empty  <= (fifo_q.size() == 0);
        ord_id_out <= (fifo_q.size() > 0) ? fifo_q[0] : 2'd0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_req_valid && ram_req_ready) begin
                if (exp_iss.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL iss_unexpected actual_addr=0x%0h expected=none", ram_addr);
                end else chk("iss", pk_iss(ram_we, ram_addr, ram_wdata), exp_iss.pop_front());
            end
            if (ord_push) begin
                if (exp_push.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL push_unexpected actual_id=%0d expected=none", ord_id);
                end else chk("ord_id", 128'(ord_id), 128'(exp_push.pop_front()));
            end
            if (rsp_valid != '0) begin
                if (exp_rsp.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_unexpected actual_vld=%b expected=none", rsp_valid);
                end else chk("rsp", pk_rsp(rsp_valid, rsp_data), exp_rsp.pop_front());
            end
        end
    end

    task automatic step(input bit auto_clr);
        @(negedge clk);
        s_rdy = req_ready; s_vld = ram_req_valid; s_addr = ram_addr; s_we = ram_we;
        s_rsp = rsp_valid; s_err = err_rsp; s_pop = ord_pop;
        @(posedge clk); #1;
        if (auto_clr) req_valid = req_valid & ~s_rdy;
    endtask

    task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_we[i] = we;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
        req_valid[i] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        bit got;
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        ram_req_ready = 1'b0; ram_rsp_valid = 1'b0; ram_rsp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_req_valid", 128'(ram_req_valid), 128'(0));
        chk("rst_ram_we", 128'(ram_we), 128'(0));
        chk("rst_ram_addr", 128'(ram_addr), 128'(0));
        chk("rst_ram_wdata", 128'(ram_wdata), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_data", 128'(rsp_data), 128'(0));
        chk("rst_err_rsp", 128'(err_rsp), 128'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Four reads, grants 0..3 back to back
        ram_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b0, 16'(16 * (i + 1)), 64'h0);
            exp_iss.push_back(pk_iss(1'b0, 16'(16 * (i + 1)), 64'h0));
            exp_push.push_back(2'(i));
            issued_rd.push_back(i);
        end
        for (int c = 0; c < 6; c++) begin
            step(1);
            chk("s1_req_ready", 128'(s_rdy), 128'((c < 4) ? onehot(c) : 4'b0));
            chk("s1_ram_req_valid", 128'(s_vld), 128'((c >= 1 && c <= 4) ? 1 : 0));
        end

        // Responses D0..D3, one-cycle latency
        for (int k = 0; k < 4; k++) begin
            ram_rsp_valid = 1'b1;
            ram_rsp_data = 64'hD0D0_0000_0000_0000 + 64'(k);
            exp_rsp.push_back(pk_rsp(onehot(issued_rd.pop_front()), 64'hD0D0_0000_0000_0000 + 64'(k)));
            step(1);
            chk("s4_rsp_latency", 128'(s_rsp), 128'((k == 0) ? 4'b0 : onehot(k - 1)));
        end
        ram_rsp_valid = 1'b0;
        step(1);
        chk("s4_rsp_last", 128'(s_rsp), 128'(4'b1000));
        step(1);
        chk("s4_rsp_pulse", 128'(s_rsp), 128'(4'b0000));

        // Write from requester 2 stalled three cycles
        ram_req_ready = 1'b0;
        pulses = 0;
        set_req(2, 1'b1, 16'h0055, 64'hCAFE_0000_0000_0055);
        exp_iss.push_back(pk_iss(1'b1, 16'h0055, 64'hCAFE_0000_0000_0055));
        step(1);
        pulses += int'(s_rdy[2]);
        chk("s2_grant", 128'(s_rdy), 128'(4'b0100));
        for (int c = 0; c < 3; c++) begin
            step(1);
            pulses += int'(s_rdy[2]);
            chk("s2_hold_valid", 128'(s_vld), 128'(1));
            chk("s2_hold_addr", 128'(s_addr), 128'(16'h0055));
            chk("s2_hold_we", 128'(s_we), 128'(1));
        end
        ram_req_ready = 1'b1;
        step(1);
        pulses += int'(s_rdy[2]);
        step(1);
        pulses += int'(s_rdy[2]);
        chk("s2_idle", 128'(s_vld), 128'(0));
        chk("s2_ready_pulses", 128'(pulses), 128'(1));

        // Fill the order FIFO with 16 reads
        for (int k = 0; k < 16; k++) begin
            set_req(k % 4, 1'b0, 16'(16'h0100 + k), 64'h0);
            exp_iss.push_back(pk_iss(1'b0, 16'(16'h0100 + k), 64'h0));
            exp_push.push_back(2'(k % 4));
            issued_rd.push_back(k % 4);
            got = 1'b0;
            for (int t = 0; t < 4 && !got; t++) begin
                step(1);
                if (s_rdy != '0) begin
                    got = 1'b1;
                    chk("s3_fill_grant", 128'(s_rdy), 128'(onehot(k % 4)));
                end
            end
            if (!got) begin
                n_checks++; n_fail++;
                $display("FAIL s3_fill_timeout actual=no_grant expected=grant_%0d", k % 4);
            end
        end
        set_req(1, 1'b0, 16'h0200, 64'h0);
        set_req(3, 1'b1, 16'h0300, 64'h3333_3333_3333_3333);
        exp_iss.push_back(pk_iss(1'b1, 16'h0300, 64'h3333_3333_3333_3333));
        exp_iss.push_back(pk_iss(1'b0, 16'h0200, 64'h0));
        exp_push.push_back(2'd1);
        step(1);
        chk("s3_full_write_wins", 128'(s_rdy), 128'(4'b1000));
        step(1);
        chk("s3_full_read_stalled", 128'(s_rdy), 128'(4'b0000));
        ram_rsp_valid = 1'b1;
        ram_rsp_data = 64'hF1F1_F1F1_F1F1_F1F1;
        exp_rsp.push_back(pk_rsp(onehot(issued_rd.pop_front()), 64'hF1F1_F1F1_F1F1_F1F1));
        step(1);
        chk("s3_pop_cycle_stall", 128'(s_rdy), 128'(4'b0000));
        chk("s3_pop", 128'(s_pop), 128'(1));
        ram_rsp_valid = 1'b0;
        issued_rd.push_back(1);
        step(1);
        chk("s3_read_after_pop", 128'(s_rdy), 128'(4'b0010));
        chk("s3_rsp_owner", 128'(s_rsp), 128'(4'b0001));
        for (int k = 0; k < 16; k++) begin
            ram_rsp_valid = 1'b1;
            ram_rsp_data = 64'hA000 + 64'(k);
            exp_rsp.push_back(pk_rsp(onehot(issued_rd.pop_front()), 64'hA000 + 64'(k)));
            step(1);
        end
        ram_rsp_valid = 1'b0;
        step(1);
        step(1);

        // Unexpected response with empty order FIFO
        chk("s5_err_before", 128'(s_err), 128'(0));
        ram_rsp_valid = 1'b1;
        ram_rsp_data = 64'hBAD;
        step(1);
        chk("s5_no_pop", 128'(s_pop), 128'(0));
        ram_rsp_valid = 1'b0;
        step(1);
        chk("s5_err_set", 128'(s_err), 128'(1));
        chk("s5_no_rsp", 128'(s_rsp), 128'(0));
        step(1);
        chk("s5_err_sticky", 128'(s_err), 128'(1));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        chk("s5_err_cleared", 128'(s_err), 128'(0));

        // Requesters 0 and 2 continuously valid
        set_req(0, 1'b1, 16'h0600, 64'h6000);
        set_req(2, 1'b1, 16'h0620, 64'h6200);
`ifdef RAM_REQ_ARB_REQ0_PRIO_EN
        for (int c = 0; c < 4; c++) begin
            exp_iss.push_back(pk_iss(1'b1, 16'h0600, 64'h6000));
            step(0);
            chk("s6_prio_req0", 128'(s_rdy), 128'(4'b0001));
        end
        req_valid[0] = 1'b0;
        exp_iss.push_back(pk_iss(1'b1, 16'h0620, 64'h6200));
        step(0);
        chk("s6_prio_req2", 128'(s_rdy), 128'(4'b0100));
        req_valid[2] = 1'b0;
`else
        for (int c = 0; c < 4; c++) begin
            exp_iss.push_back((c % 2 == 0) ? pk_iss(1'b1, 16'h0600, 64'h6000) : pk_iss(1'b1, 16'h0620, 64'h6200));
            step(0);
            chk("s6_rr_alternate", 128'(s_rdy), 128'((c % 2 == 0) ? 4'b0001 : 4'b0100));
        end
        req_valid = '0;
`endif
        step(1);
        chk("s6_drain_no_grant", 128'(s_rdy), 128'(4'b0000));
        step(1);
        chk("s6_idle", 128'(s_vld), 128'(0));

        step(1);
        chk("end_iss_queue", 128'(exp_iss.size()), 128'(0));
        chk("end_push_queue", 128'(exp_push.size()), 128'(0));
        chk("end_rsp_queue", 128'(exp_rsp.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
